// File: rtl/hamming_decoder_stream_pkg.sv
// Shared types and elaboration helpers for the streaming Hamming decoder and its syndrome unit.
package hamming_decoder_stream_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CORRECTED,
    ERR_UNCORRECTABLE
  } err_kind_e;

  // Smallest p with 2^p >= data_width + p + 1 (single-error-correcting Hamming code).
  function automatic int get_hamming_parity_width(input int data_width);
    int p;
    p = 1;
    while ((1 << p) < (data_width + p + 1)) p++;
    return p;
  endfunction

  function automatic logic is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome: bit i is the XOR of every block bit whose 1-indexed position has bit i set.
module hamming_syndrome
  import hamming_decoder_stream_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  localparam int PARITY_WIDTH = get_hamming_parity_width(DATA_WIDTH),
  localparam int BLOCK_WIDTH  = DATA_WIDTH + PARITY_WIDTH
) (
  input  logic [BLOCK_WIDTH-1:0]  block,
  output logic [PARITY_WIDTH-1:0] syndrome
);

  always_comb begin
    syndrome = '0;
    for (int i = 0; i < PARITY_WIDTH; i++) begin
      for (int j = 0; j < BLOCK_WIDTH; j++) begin
        if ((((j + 1) >> i) & 1) == 1) syndrome[i] = syndrome[i] ^ block[j];
      end
    end
  end

endmodule

// File: rtl/hamming_decoder_stream.sv
// Two-stage streaming Hamming decoder: syndrome at stage 1, correction/extraction at stage 2,
// with saturating corrected/uncorrectable counters updated on output handshakes.
module hamming_decoder_stream
  import hamming_decoder_stream_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int COUNT_WIDTH  = 16,
  localparam int PARITY_WIDTH = get_hamming_parity_width(DATA_WIDTH),
  localparam int BLOCK_WIDTH  = DATA_WIDTH + PARITY_WIDTH
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_WIDTH-1:0]  in_block,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PARITY_WIDTH-1:0] out_syndrome,
  output logic                    out_corrected,
  output logic                    out_uncorrectable,
  input  logic                    clear_counters,
  output logic [COUNT_WIDTH-1:0]  corrected_count,
  output logic [COUNT_WIDTH-1:0]  uncorrectable_count
);

  function automatic err_kind_e classify(input logic [PARITY_WIDTH-1:0] s);
    if (s == '0) return ERR_NONE;
    else if (int'(s) <= BLOCK_WIDTH) return ERR_CORRECTED;
    else return ERR_UNCORRECTABLE;
  endfunction

  // One-hot at position s; all-zero when s is 0 or points past the block.
  function automatic logic [BLOCK_WIDTH-1:0] flip_mask(input logic [PARITY_WIDTH-1:0] s);
    logic [BLOCK_WIDTH-1:0] m;
    for (int j = 0; j < BLOCK_WIDTH; j++) m[j] = (int'(s) == (j + 1));
    return m;
  endfunction

  // Inverse of encoder placement: non-power-of-two positions carry data, LSB first.
  function automatic logic [DATA_WIDTH-1:0] extract(input logic [BLOCK_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int j = 0; j < BLOCK_WIDTH; j++) begin
      if (!is_pow2(j + 1)) begin
        d[k] = b[j];
        k++;
      end
    end
    return d;
  endfunction

  logic [PARITY_WIDTH-1:0] syn_comb;
  logic                    ld_p1, ld_p2, hs_out;

  logic                    vld_p1_q, vld_p1_d;
  logic [BLOCK_WIDTH-1:0]  blk_p1_q, blk_p1_d;
  logic [PARITY_WIDTH-1:0] syn_p1_q, syn_p1_d;

  logic                    vld_p2_q, vld_p2_d;
  logic [DATA_WIDTH-1:0]   data_p2_q, data_p2_d;
  logic [PARITY_WIDTH-1:0] syn_p2_q, syn_p2_d;
  logic                    corr_p2_q, corr_p2_d;
  logic                    unc_p2_q, unc_p2_d;
  err_kind_e               kind_p1;

  logic [COUNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d;
  logic [COUNT_WIDTH-1:0]  unc_cnt_q, unc_cnt_d;

  hamming_syndrome #(.DATA_WIDTH(DATA_WIDTH)) u_syndrome (
    .block    (in_block),
    .syndrome (syn_comb)
  );

  // Each stage loads when empty or when its occupant moves on this cycle.
  always_comb begin
    ld_p2  = !vld_p2_q || out_ready;
    ld_p1  = !vld_p1_q || ld_p2;
    hs_out = vld_p2_q && out_ready;
  end

  assign in_ready = ld_p1;

  // Stage 1: capture block and its syndrome
  always_comb begin
    vld_p1_d = vld_p1_q;
    blk_p1_d = blk_p1_q;
    syn_p1_d = syn_p1_q;
    if (ld_p1) begin
      vld_p1_d = in_valid;
      blk_p1_d = in_block;
      syn_p1_d = syn_comb;
    end
  end

  // Stage 2: correct, extract and flag
  always_comb begin
    kind_p1   = classify(syn_p1_q);
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    syn_p2_d  = syn_p2_q;
    corr_p2_d = corr_p2_q;
    unc_p2_d  = unc_p2_q;
    if (ld_p2) begin
      vld_p2_d  = vld_p1_q;
      data_p2_d = extract(blk_p1_q ^ flip_mask(syn_p1_q));
      syn_p2_d  = syn_p1_q;
      corr_p2_d = (kind_p1 == ERR_CORRECTED);
      unc_p2_d  = (kind_p1 == ERR_UNCORRECTABLE);
    end
  end

  always_comb begin
    corr_cnt_d = corr_cnt_q;
    unc_cnt_d  = unc_cnt_q;
    if (clear_counters) begin
      corr_cnt_d = '0;
      unc_cnt_d  = '0;
    end else if (hs_out) begin
      if (corr_p2_q && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + 1'b1;
      if (unc_p2_q && (unc_cnt_q != '1))   unc_cnt_d  = unc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      data_p2_q  <= '0;
      syn_p2_q   <= '0;
      corr_p2_q  <= 1'b0;
      unc_p2_q   <= 1'b0;
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      data_p2_q  <= data_p2_d;
      syn_p2_q   <= syn_p2_d;
      corr_p2_q  <= corr_p2_d;
      unc_p2_q   <= unc_p2_d;
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clock) begin
    blk_p1_q <= blk_p1_d;
    syn_p1_q <= syn_p1_d;
  end

  assign out_valid           = vld_p2_q;
  assign out_data            = data_p2_q;
  assign out_syndrome        = syn_p2_q;
  assign out_corrected       = corr_p2_q;
  assign out_uncorrectable   = unc_p2_q;
  assign corrected_count     = corr_cnt_q;
  assign uncorrectable_count = unc_cnt_q;

endmodule
